lc3_decode: RTL and testbench

Registered Decode stage of the LC3 pipeline. Sits directly downstream of Fetch and consumes the `decode_in` bundle (`enable_decode`, `instr_dout`, `npc_in`, `psr`). When enabled, it latches the instruction and its next-PC and produces the control words consumed by Execute, Memory and Writeback. All outputs are registered and hold between enables.

---
 rtl/lc3_pkg.sv | 32 +++
 rtl/lc3_decode_ctrl.sv | 71 +++++++
 rtl/lc3_decode.sv | 75 +++++++
 tb/tb_lc3_decode.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC3 decode types: opcode enum, control-field encodings and the
// packed Execute control word.
package lc3_pkg;

   typedef enum logic [3:0] {
      OP_BR   = 4'h0, OP_ADD = 4'h1, OP_LD  = 4'h2, OP_ST   = 4'h3,
      OP_JSR  = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR  = 4'h7,
      OP_RTI  = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI  = 4'hB,
      OP_JMP  = 4'hC, OP_RES = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
   } lc3_opcode_e;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_AND = 2'b01;
   localparam logic [1:0] ALU_NOT = 2'b10;

   localparam logic [1:0] PCSEL1_NONE = 2'b00;
   localparam logic [1:0] PCSEL1_OFF9 = 2'b01;
   localparam logic [1:0] PCSEL1_OFF6 = 2'b10;
   localparam logic [1:0] PCSEL1_ZERO = 2'b11;

   localparam logic [1:0] WSEL_ALU = 2'b00;
   localparam logic [1:0] WSEL_MEM = 2'b01;
   localparam logic [1:0] WSEL_NPC = 2'b10;

   typedef struct packed {
      logic [1:0] alu_control;
      logic [1:0] pcselect1;
      logic       pcselect2;
      logic       op2select;
   } e_control_t;

endpackage

// File: rtl/lc3_decode_ctrl.sv
// Combinational opcode decoder: instruction word to Execute/Writeback/Memory
// control words plus an unsupported-opcode flag.
module lc3_decode_ctrl
   import lc3_pkg::*;
(
   input  logic [15:0] instr_i,
   output logic [5:0]  e_control_o,
   output logic [1:0]  w_control_o,
   output logic        mem_control_o,
   output logic        illegal_o
);

   e_control_t ec;

   always_comb begin
      ec            = '0;
      w_control_o   = WSEL_ALU;
      mem_control_o = 1'b0;
      illegal_o     = 1'b0;
      case (lc3_opcode_e'(instr_i[15:12]))
         OP_ADD: begin
            ec.alu_control = ALU_ADD;
            ec.op2select   = ~instr_i[5];
         end
         OP_AND: begin
            ec.alu_control = ALU_AND;
            ec.op2select   = ~instr_i[5];
         end
         OP_NOT: begin
            ec.alu_control = ALU_NOT;
            ec.op2select   = 1'b1;
         end
         OP_BR, OP_ST: begin
            ec.pcselect1 = PCSEL1_OFF9;
            ec.pcselect2 = 1'b1;
         end
         OP_LD: begin
            ec.pcselect1 = PCSEL1_OFF9;
            ec.pcselect2 = 1'b1;
            w_control_o  = WSEL_MEM;
         end
         OP_LDI: begin
            ec.pcselect1  = PCSEL1_OFF9;
            ec.pcselect2  = 1'b1;
            w_control_o   = WSEL_MEM;
            mem_control_o = 1'b1;
         end
         OP_STI: begin
            ec.pcselect1  = PCSEL1_OFF9;
            ec.pcselect2  = 1'b1;
            mem_control_o = 1'b1;
         end
         OP_LEA: begin
            ec.pcselect1 = PCSEL1_OFF9;
            ec.pcselect2 = 1'b1;
            w_control_o  = WSEL_NPC;
         end
         OP_LDR: begin
            ec.pcselect1 = PCSEL1_OFF6;
            w_control_o  = WSEL_MEM;
         end
         OP_STR: ec.pcselect1 = PCSEL1_OFF6;
         OP_JMP: ec.pcselect1 = PCSEL1_ZERO;
         // JSR, RTI, reserved and TRAP: flag it and leave every control at zero
         default: illegal_o = 1'b1;
      endcase
   end

   assign e_control_o = ec;

endmodule

// File: rtl/lc3_decode.sv
// Registered LC3 Decode stage: captures instruction, NPC and PSR on enable and
// registers the decoded control words; everything holds between enables.
module lc3_decode
   import lc3_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        enable_decode,
   input  logic [15:0] instr_dout,
   input  logic [15:0] npc_in,
   input  logic [2:0]  psr,
   output logic [15:0] ir,
   output logic [15:0] npc_out,
   output logic [5:0]  e_control,
   output logic [1:0]  w_control,
   output logic        mem_control,
   output logic [2:0]  psr_out,
   output logic        decode_valid,
   output logic        illegal_op
);

   logic [5:0]  ec_d;
   logic [1:0]  wc_d;
   logic        mc_d;
   logic        ill_d;

   logic [15:0] ir_q, npc_q;
   logic [5:0]  ec_q;
   logic [1:0]  wc_q;
   logic        mc_q, ill_q, vld_q;
   logic [2:0]  psr_q;

   lc3_decode_ctrl u_ctrl (
      .instr_i       (instr_dout),
      .e_control_o   (ec_d),
      .w_control_o   (wc_d),
      .mem_control_o (mc_d),
      .illegal_o     (ill_d)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         ir_q   <= '0;
         npc_q  <= '0;
         ec_q   <= '0;
         wc_q   <= '0;
         mc_q   <= 1'b0;
         ill_q  <= 1'b0;
         psr_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= enable_decode;
         // Decoder output is only sampled on enable, so a floating bus while idle is harmless
         if (enable_decode) begin
            ir_q  <= instr_dout;
            npc_q <= npc_in;
            ec_q  <= ec_d;
            wc_q  <= wc_d;
            mc_q  <= mc_d;
            ill_q <= ill_d;
            psr_q <= psr;
         end
      end
   end

   assign ir           = ir_q;
   assign npc_out      = npc_q;
   assign e_control    = ec_q;
   assign w_control    = wc_q;
   assign mem_control  = mc_q;
   assign psr_out      = psr_q;
   assign decode_valid = vld_q;
   assign illegal_op   = ill_q;

endmodule

// File: tb/tb_lc3_decode.sv
// Scoreboard bench for lc3_decode: stimulus pushes hand-computed expectations,
// a negedge monitor compares every cycle against the held/popped expectation.
module tb_lc3_decode;

   typedef struct {
      logic [15:0] ir;
      logic [15:0] npc;
      logic [5:0]  ec;
      logic [1:0]  wc;
      logic        mc;
      logic [2:0]  psr;
      logic        ill;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable_decode;
   logic [15:0] instr_dout;
   logic [15:0] npc_in;
   logic [2:0]  psr;
   logic [15:0] ir, npc_out;
   logic [5:0]  e_control;
   logic [1:0]  w_control;
   logic        mem_control, decode_valid, illegal_op;
   logic [2:0]  psr_out;

   int checks = 0;
   int errors = 0;
   exp_t q[$];
   exp_t held;
   logic exp_vld = 1'b0;
   bit   done = 1'b0;

   lc3_decode dut (
      .clock        (clock),
      .reset        (reset),
      .enable_decode(enable_decode),
      .instr_dout   (instr_dout),
      .npc_in       (npc_in),
      .psr          (psr),
      .ir           (ir),
      .npc_out      (npc_out),
      .e_control    (e_control),
      .w_control    (w_control),
      .mem_control  (mem_control),
      .psr_out      (psr_out),
      .decode_valid (decode_valid),
      .illegal_op   (illegal_op)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   // Expected valid follows the inputs seen at each active edge
   always @(posedge clock) begin
      if (!reset) begin
         exp_vld = 1'b0;
         held    = '{default: '0};
      end else begin
         exp_vld = enable_decode;
      end
   end

   always @(negedge clock) begin
      if (!done) begin
         chk("decode_valid", {15'b0, decode_valid}, {15'b0, exp_vld});
         if (exp_vld) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL scoreboard_underflow actual=empty required=entry @%0t", $time);
            end else begin
               held = q.pop_front();
            end
         end
         chk("ir",          ir,                      held.ir);
         chk("npc_out",     npc_out,                 held.npc);
         chk("e_control",   {10'b0, e_control},      {10'b0, held.ec});
         chk("w_control",   {14'b0, w_control},      {14'b0, held.wc});
         chk("mem_control", {15'b0, mem_control},    {15'b0, held.mc});
         chk("psr_out",     {13'b0, psr_out},        {13'b0, held.psr});
         chk("illegal_op",  {15'b0, illegal_op},     {15'b0, held.ill});
      end
   end

   task automatic step(input logic rst, input logic en, input logic [15:0] ins,
                       input logic [15:0] npc, input logic [2:0] p,
                       input logic [5:0] ec, input logic [1:0] wc,
                       input logic mc, input logic ill);
      exp_t e;
      reset = rst; enable_decode = en; instr_dout = ins; npc_in = npc; psr = p;
      if (rst && en) begin
         e = '{ir: ins, npc: npc, ec: ec, wc: wc, mc: mc, psr: p, ill: ill};
         q.push_back(e);
      end
      @(posedge clock); #1;
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 3'($urandom), '0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; enable_decode = 1'b1; instr_dout = 16'h1042; npc_in = 16'h3001; psr = 3'b010;
      // reset held with enable high: nothing captured
      step(1'b0, 1'b1, 16'h1042, 16'h3001, 3'b010, '0, '0, 0, 0);
      step(1'b0, 1'b1, 16'h1042, 16'h3001, 3'b010, '0, '0, 0, 0);
      //     rst  en   instr     npc       psr     e_control  w     m  ill
      step(1, 1, 16'h1042, 16'h3001, 3'b010, 6'b000001, 2'b00, 0, 0); // ADD reg
      idle();
      step(1, 1, 16'hA205, 16'h3002, 3'b001, 6'b000110, 2'b01, 1, 0); // LDI
      step(1, 1, 16'h7442, 16'h3003, 3'b100, 6'b001000, 2'b00, 0, 0); // STR
      step(1, 1, 16'hE3FF, 16'h3004, 3'b010, 6'b000110, 2'b10, 0, 0); // LEA
      for (int i = 0; i < 5; i++) idle();
      step(1, 1, 16'hF025, 16'h3005, 3'b001, 6'b000000, 2'b00, 0, 1); // TRAP
      step(1, 1, 16'h1261, 16'h3006, 3'b100, 6'b000000, 2'b00, 0, 0); // ADD imm
      step(1, 1, 16'h5042, 16'h3007, 3'b010, 6'b010001, 2'b00, 0, 0); // AND reg
      step(1, 1, 16'h5062, 16'h3008, 3'b010, 6'b010000, 2'b00, 0, 0); // AND imm
      step(1, 1, 16'h967F, 16'h3009, 3'b001, 6'b100001, 2'b00, 0, 0); // NOT
      step(1, 1, 16'h0E05, 16'h300A, 3'b100, 6'b000110, 2'b00, 0, 0); // BR
      step(1, 1, 16'h2405, 16'h300B, 3'b010, 6'b000110, 2'b01, 0, 0); // LD
      step(1, 1, 16'hB205, 16'h300C, 3'b010, 6'b000110, 2'b00, 1, 0); // STI
      step(1, 1, 16'h3205, 16'h300D, 3'b001, 6'b000110, 2'b00, 0, 0); // ST
      step(1, 1, 16'h6642, 16'h300E, 3'b001, 6'b001000, 2'b01, 0, 0); // LDR
      step(1, 1, 16'h4800, 16'h300F, 3'b100, 6'b000000, 2'b00, 0, 1); // JSR
      step(1, 1, 16'h8000, 16'h3010, 3'b100, 6'b000000, 2'b00, 0, 1); // RTI
      step(1, 1, 16'hD000, 16'h3011, 3'b100, 6'b000000, 2'b00, 0, 1); // reserved
      idle();
      // reset wins over an enabled JMP on the same edge
      step(0, 1, 16'hC1C0, 16'h3012, 3'b010, '0, '0, 0, 0);
      idle();
      step(1, 1, 16'hC1C0, 16'h3012, 3'b010, 6'b001100, 2'b00, 0, 0); // JMP
      idle();
      idle();
      @(negedge clock); #1;
      done = 1'b1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover actual=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
